// File: rtl/pipe_issue_arbiter.sv
// Round-robin, burst-capable issue arbiter feeding one registered slot into a
// stallable valid/allowin pipeline stage.
module pipe_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 2,
  parameter int SRCW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_allowin,
  input  logic                  flush,
  input  logic                  pipe_allowin,
  output logic                  pipe_validin,
  output logic [WIDTH-1:0]      pipe_datain,
  output logic [SRCW-1:0]       pipe_srcid
);

  localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);
  localparam logic [SRCW-1:0] SRC_LAST = SRCW'(NREQ - 1);
  localparam logic [SRCW:0]   NREQ_EXT = (SRCW + 1)'(NREQ);

  logic             slot_valid_reg;
  logic [WIDTH-1:0] slot_data_reg;
  logic [SRCW-1:0]  slot_src_reg;
  logic [SRCW-1:0]  owner_reg;
  logic [CNTW-1:0]  burst_cnt_reg;
  logic             fresh_reg;

  logic             slot_allowin;
  logic             any_valid;
  logic             transfer;
  logic [SRCW-1:0]  owner_inc;
  logic [SRCW-1:0]  start;
  logic [SRCW-1:0]  win;
  logic [CNTW-1:0]  burst_cnt_next;
  logic [WIDTH-1:0] req_word [NREQ];
  logic [SRCW-1:0]  cand_idx [NREQ];
  logic [NREQ-1:0]  cand_valid;

  assign owner_inc = (owner_reg == SRC_LAST) ? '0 : owner_reg + 1'b1;
  // The first grant after reset opens a fresh burst so requester 0 gets a full run.
  assign start = (burst_cnt_reg == CNT_LAST && !fresh_reg) ? owner_inc : owner_reg;

  // Candidate gi is the requester gi positions after the search start.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [SRCW:0] sum;
      assign req_word[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign sum            = {1'b0, start} + (SRCW + 1)'(gi);
      assign cand_idx[gi]   = (sum >= NREQ_EXT) ? SRCW'(sum - NREQ_EXT) : sum[SRCW-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_valid[i]) win = cand_idx[i];
    end
  end

  assign any_valid    = |req_valid;
  assign slot_allowin = !slot_valid_reg || pipe_allowin;
  assign transfer     = slot_allowin && any_valid && !flush && !rst;

  always_comb begin
    req_allowin = '0;
    if (transfer) req_allowin[win] = 1'b1;
  end

  assign burst_cnt_next = (win == owner_reg && !fresh_reg && burst_cnt_reg != CNT_LAST)
                          ? burst_cnt_reg + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_reg <= 1'b0;
      slot_data_reg  <= '0;
      slot_src_reg   <= '0;
      owner_reg      <= '0;
      burst_cnt_reg  <= '0;
      fresh_reg      <= 1'b1;
    end else if (flush) begin
      slot_valid_reg <= 1'b0;
    end else if (transfer) begin
      slot_valid_reg <= 1'b1;
      slot_data_reg  <= req_word[win];
      slot_src_reg   <= win;
      owner_reg      <= win;
      burst_cnt_reg  <= burst_cnt_next;
      fresh_reg      <= 1'b0;
    end else if (slot_allowin) begin
      slot_valid_reg <= 1'b0;
    end
  end

  assign pipe_validin = slot_valid_reg;
  assign pipe_datain  = slot_data_reg;
  assign pipe_srcid   = slot_src_reg;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Randomized and directed bench for pipe_issue_arbiter against a grant-streak
// reference model.
module tb_pipe_issue_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int BURST = 2;
  localparam int SRCW  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_allowin;
  logic                  flush = 1'b0;
  logic                  pipe_allowin = 1'b1;
  logic                  pipe_validin;
  logic [WIDTH-1:0]      pipe_datain;
  logic [SRCW-1:0]       pipe_srcid;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: slot contents, current owner and its consecutive-grant streak
  bit              m_valid;
  logic [WIDTH-1:0] m_data;
  int              m_src, m_owner, m_streak, m_win;
  bit              m_grant;
  bit              cur_rst, cur_flush, cur_pa;
  logic [NREQ-1:0] exp_allowin;
  logic [WIDTH-1:0] words [NREQ];

  pipe_issue_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_allowin(req_allowin), .flush(flush), .pipe_allowin(pipe_allowin),
    .pipe_validin(pipe_validin), .pipe_datain(pipe_datain), .pipe_srcid(pipe_srcid)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [NREQ-1:0] v, input bit f, input bit pa, input bit r);
    int start;
    int idx;
    @(negedge clk);
    req_valid = v; flush = f; pipe_allowin = pa; rst = r;
    cur_rst = r; cur_flush = f; cur_pa = pa;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];
    start = (m_streak >= BURST) ? (m_owner + 1) % NREQ : m_owner;
    m_win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (m_win < 0 && v[idx]) m_win = idx;
    end
    m_grant = !r && !f && (!m_valid || pa) && (m_win >= 0);
    exp_allowin = '0;
    if (m_grant) exp_allowin[m_win] = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_owner = 0; m_streak = 0;
    end else if (cur_flush) begin
      m_valid = 0;
    end else if (!m_valid || cur_pa) begin
      if (m_win >= 0) begin
        m_valid = 1; m_data = words[m_win]; m_src = m_win;
        if (m_win == m_owner && m_streak < BURST) m_streak++;
        else m_streak = 1;
        m_owner = m_win;
        $display("[TB] xfer src=%0d data=%08h", m_win, words[m_win]);
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      apply('1, 0, 1, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) words[i] = 32'h10 + i;
    for (int c = 0; c < 2; c++) begin
      apply('1, 0, 1, 1);
      n_tests++;
      if (req_allowin !== '0) begin
        n_fail++; $display("FAIL reset_allowin got=%b exp=0", req_allowin);
      end
      tick();
      n_tests++;
      if ({pipe_validin, pipe_srcid, pipe_datain} !== '0) begin
        n_fail++; $display("FAIL reset_out got v=%b s=%0d d=%h exp all 0", pipe_validin, pipe_srcid, pipe_datain);
      end
    end
    // mid-operation reset: no grant on the reset cycle, slot cleared
    for (int c = 0; c < 3; c++) begin apply('1, 0, 1, 0); tick(); end
    apply('1, 0, 1, 1);
    n_tests++;
    if (req_allowin !== '0) begin
      n_fail++; $display("FAIL midreset_allowin got=%b exp=0", req_allowin);
    end
    tick();
    n_tests++;
    if ({pipe_validin, pipe_srcid, pipe_datain} !== '0) begin
      n_fail++; $display("FAIL midreset_out got v=%b s=%0d d=%h exp all 0", pipe_validin, pipe_srcid, pipe_datain);
    end
  endtask

  task automatic test_all_requesting();
    int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    for (int i = 0; i < NREQ; i++) words[i] = 32'h10 + i;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      apply('1, 0, 1, 0);
      n_tests++;
      if (req_allowin !== exp_allowin) begin
        n_fail++; $display("FAIL allreq_allowin c=%0d got=%b exp=%b", c, req_allowin, exp_allowin);
      end
      tick();
      n_tests++;
      if (pipe_validin !== 1'b1 || pipe_srcid !== SRCW'(seq[c]) || pipe_datain !== 32'h10 + seq[c]) begin
        n_fail++; $display("FAIL allreq_seq c=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                           c, pipe_validin, pipe_srcid, pipe_datain, seq[c], 32'h10 + seq[c]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      apply(4'b0100, 0, 1, 0);
      n_tests++;
      if (req_allowin !== 4'b0100) begin
        n_fail++; $display("FAIL single_allowin c=%0d got=%b exp=0100", c, req_allowin);
      end
      tick();
      n_tests++;
      if (pipe_validin !== 1'b1 || pipe_srcid !== 2'd2 || pipe_datain !== 32'h12) begin
        n_fail++; $display("FAIL single_out c=%0d got v=%b s=%0d d=%h exp v=1 s=2 d=12", c, pipe_validin, pipe_srcid, pipe_datain);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_src [2] = '{1, 2};
    do_reset();
    apply(4'b0010, 0, 1, 0); tick();
    for (int c = 0; c < 3; c++) begin
      apply('1, 0, 0, 0);
      n_tests++;
      if (req_allowin !== '0) begin
        n_fail++; $display("FAIL stall_allowin c=%0d got=%b exp=0", c, req_allowin);
      end
      tick();
      n_tests++;
      if (pipe_validin !== 1'b1 || pipe_srcid !== 2'd1 || pipe_datain !== 32'h11) begin
        n_fail++; $display("FAIL stall_hold c=%0d got v=%b s=%0d d=%h exp v=1 s=1 d=11", c, pipe_validin, pipe_srcid, pipe_datain);
      end
    end
    // owner 1 has one grant, so it keeps one more before 2
    for (int c = 0; c < 2; c++) begin
      apply('1, 0, 1, 0);
      tick();
      n_tests++;
      if (pipe_srcid !== SRCW'(exp_src[c]) || pipe_datain !== 32'h10 + exp_src[c]) begin
        n_fail++; $display("FAIL stall_resume c=%0d got s=%0d d=%h exp s=%0d", c, pipe_srcid, pipe_datain, exp_src[c]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin apply('1, 0, 1, 0); tick(); end
    apply('1, 1, 1, 0);
    n_tests++;
    if (req_allowin !== '0) begin
      n_fail++; $display("FAIL flush_allowin got=%b exp=0", req_allowin);
    end
    tick();
    n_tests++;
    if (pipe_validin !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got=%b exp=0", pipe_validin);
    end
    apply('1, 0, 1, 0);
    n_tests++;
    if (req_allowin !== 4'b0010) begin
      n_fail++; $display("FAIL flush_resume_allowin got=%b exp=0010", req_allowin);
    end
    tick();
    n_tests++;
    if (pipe_validin !== 1'b1 || pipe_srcid !== 2'd1) begin
      n_fail++; $display("FAIL flush_resume got v=%b s=%0d exp v=1 s=1", pipe_validin, pipe_srcid);
    end
  endtask

  task automatic test_mid_burst_drop();
    logic [NREQ-1:0] vs [4] = '{4'b1001, 4'b1000, 4'b1001, 4'b1001};
    int exp_src [4] = '{0, 3, 3, 0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(vs[c], 0, 1, 0);
      n_tests++;
      if (req_allowin !== exp_allowin) begin
        n_fail++; $display("FAIL drop_allowin c=%0d got=%b exp=%b", c, req_allowin, exp_allowin);
      end
      tick();
      n_tests++;
      if (pipe_validin !== 1'b1 || pipe_srcid !== SRCW'(exp_src[c]) || pipe_datain !== 32'h10 + exp_src[c]) begin
        n_fail++; $display("FAIL drop_seq c=%0d got s=%0d d=%h exp s=%0d", c, pipe_srcid, pipe_datain, exp_src[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) words[i] = $urandom;
      apply(NREQ'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 0);
      n_tests++;
      if (req_allowin !== exp_allowin) begin
        n_fail++; $display("FAIL rand_allowin c=%0d got=%b exp=%b", c, req_allowin, exp_allowin);
      end
      tick();
      n_tests++;
      if ({pipe_validin, pipe_srcid, pipe_datain} !== {m_valid, SRCW'(m_src), m_data}) begin
        n_fail++; $display("FAIL rand_out c=%0d got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                           c, pipe_validin, pipe_srcid, pipe_datain, m_valid, m_src, m_data);
      end
    end
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_src = 0; m_owner = 0; m_streak = 0; m_win = -1;
    test_reset();
    test_all_requesting();
    test_single();
    test_backpressure();
    test_flush();
    test_mid_burst_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
